// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg: select encodings, register-address width and scoreboard entry type shared by forward_ctrl and fwd_pick
package forward_ctrl_pkg;
   localparam int REG_AW = 5;
   localparam logic [1:0] SEL_RF    = 2'b00;
   localparam logic [1:0] SEL_EXMEM = 2'b01;
   localparam logic [1:0] SEL_MEMWB = 2'b10;
   localparam logic [1:0] SEL_IMM   = 2'b11;
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dest;
      logic              reg_write;
      logic              mem_read;
   } sb_entry_t;
endpackage

// File: rtl/forward_ctrl_fwd_pick.sv
// fwd_pick: chooses the forwarding source for one EX operand
// Ports: src (EX source register), mem / wb (scoreboard entries), sel (2-bit mux select).
module fwd_pick
   import forward_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  sb_entry_t         mem,
   input  sb_entry_t         wb,
   output logic [1:0]        sel
);
   logic mem_hit, wb_hit;
   always_comb begin
      // A load sitting in MEM has no data yet; the load-use stall keeps it from ever being needed here.
      mem_hit = mem.valid && mem.reg_write && !mem.mem_read && mem.dest != '0 && mem.dest == src;
      wb_hit  = wb.valid && wb.reg_write && wb.dest != '0 && wb.dest == src;
      sel     = mem_hit ? SEL_EXMEM : wb_hit ? SEL_MEMWB : SEL_RF;
   end
endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: EX-operand forwarding selects and load-use stall from a 3-entry EX/MEM/WB scoreboard
// Ports: clk, reset (sync, active-high); id_* describe the ID-stage instruction; flush kills it;
// sel_a/sel_b drive the EX operand muxes; stall holds PC and IF/ID.
// Optional: FORWARD_CTRL_PERF_EN adds stall_count, a saturating count of stalled cycles.
module forward_ctrl #(
   parameter int REG_AW = forward_ctrl_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_alu_src,
   input  logic              flush,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              stall
`ifdef FORWARD_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_count
`endif
);
   import forward_ctrl_pkg::*;
   sb_entry_t         ex_q, mem_q, wb_q, ex_d;
   logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rs_d, ex_rt_d;
   logic              ex_alu_src_q, ex_alu_src_d, load_use, accept;
   logic [1:0]        pick_b;

   fwd_pick u_pick_a (.src(ex_rs_q), .mem(mem_q), .wb(wb_q), .sel(sel_a));
   fwd_pick u_pick_b (.src(ex_rt_q), .mem(mem_q), .wb(wb_q), .sel(pick_b));

   always_comb begin
      load_use     = ex_q.valid && ex_q.mem_read && ex_q.dest != '0 &&
                     (ex_q.dest == id_rs || (!id_alu_src && ex_q.dest == id_rt));
      stall        = id_valid && !flush && load_use;
      accept       = id_valid && !stall && !flush;
      // Bubbles also clear the EX source fields so they can never raise a forward select.
      ex_d         = accept ? sb_entry_t'{valid: 1'b1, dest: id_dest, reg_write: id_reg_write,
                                          mem_read: id_mem_read} : '0;
      ex_rs_d      = accept ? id_rs : '0;
      ex_rt_d      = accept ? id_rt : '0;
      ex_alu_src_d = accept && id_alu_src;
      sel_b        = ex_alu_src_q ? SEL_IMM : pick_b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_alu_src_q <= 1'b0;
      end else begin
         ex_q         <= ex_d;
         mem_q        <= ex_q;
         wb_q         <= mem_q;
         ex_rs_q      <= ex_rs_d;
         ex_rt_q      <= ex_rt_d;
         ex_alu_src_q <= ex_alu_src_d;
      end
   end

`ifdef FORWARD_CTRL_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;
   always_comb stall_count_d = (stall && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
   always_ff @(posedge clk) stall_count_q <= reset ? '0 : stall_count_d;
   assign stall_count = stall_count_q;
`endif
endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 Parameter: REG_AW, default 5, register-address width.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: id_valid  input  1  ID stage holds a real instruction.
REQ-005 Port: id_rs, id_rt  input  REG_AW  ID source register addresses.
REQ-006 Port: id_dest  input  REG_AW  ID destination register.
REQ-007 Port: id_reg_write  input  1  ID instruction writes id_dest.
REQ-008 Port: id_mem_read  input  1  ID instruction is a load.
REQ-009 Port: id_alu_src  input  1  ID instruction uses an immediate as ALU operand B.
REQ-010 Port: flush  input  1  kill the ID instruction (taken branch or jump).
REQ-011 Port: sel_a  output  2  select for EX operand-A 32-bit 4:1 mux.
REQ-012 Port: sel_b  output  2  select for EX operand-B 32-bit 4:1 mux.
REQ-013 Port: stall  output  1  hold PC and IF/ID; bubble into EX.

Function
REQ-014 Select encoding SHALL be: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back value, 11 immediate (sel_b only; sel_a never 11).
REQ-015 Block SHALL keep a 3-entry scoreboard (EX, MEM, WB), each entry {valid, dest, reg_write, mem_read}, plus registered EX-stage rs, rt, alu_src.
REQ-016 Each clock, the scoreboard SHALL shift EX->MEM->WB; the EX entry loads from the ID ports when id_valid=1, stall=0, and flush=0, otherwise it loads a bubble (valid=0).
REQ-017 stall SHALL be combinational: 1 when id_valid, EX entry is a valid load, and EX dest is nonzero and equals id_rs, or equals id_rt when id_alu_src=0.
REQ-018 flush=1 SHALL force stall=0 in the same cycle.
REQ-019 sel_a SHALL be combinational from registered state: 01 if MEM entry valid, reg_write, nonzero dest equal to EX rs; else 10 if the same holds for the WB entry; else 00.
REQ-020 sel_b SHALL be 11 when EX alu_src=1; otherwise the REQ-019 rule applied to EX rt.
REQ-021 Register 0 SHALL never be forwarded or cause a stall.
REQ-022 MEM-stage match SHALL take priority over WB-stage match (youngest producer wins).
REQ-023 A load in the MEM entry SHALL NOT produce select 01; the REQ-017 stall guarantees it has reached WB before use.
REQ-024 Latency: a producer at ID in cycle N is forwardable to a consumer at EX via 01 in cycle N+2 and via 10 in N+3.

Reset
REQ-025 While reset=1 at a clock edge, all scoreboard valid bits and registered EX fields SHALL clear to 0.
REQ-026 After reset, sel_a=00, sel_b=00, stall=0 until a valid instruction enters EX.
REQ-027 Reset asserted mid-stall SHALL drop stall the next cycle, and no forwarding SHALL reference pre-reset entries.

Configuration
REQ-028 Macro FORWARD_CTRL_PERF_EN defined: add output stall_count (32 bits), reset to 0, incremented each cycle stall=1, saturating at 0xFFFFFFFF; port absent when undefined, with all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the select-encoding constants (SEL_RF, SEL_EXMEM, SEL_MEMWB, SEL_IMM), REG_AW, and the scoreboard-entry typedef.
REQ-030 One sub-module, fwd_pick, SHALL map (source address, MEM entry, WB entry) to a 2-bit select and be instantiated for operands A and B.

Verification
REQ-031 add $3 in cycle N, then add $4,$3,$5 -> sel_a=01 in the cycle the consumer is in EX; sel_b=00.
REQ-032 add $3; nop; sub $6,$7,$3 -> sel_b=10; with $3 written by both MEM and WB entries -> sel_b=01.
REQ-033 lw $8; add $9,$8,$1 -> stall=1 for exactly one cycle, EX gets a bubble, then sel_a=10.
REQ-034 Producer dest $0 with consumer rs=$0 -> sel_a=00, stall=0; addi with rt match -> sel_b=11.
REQ-035 Load-use stall with flush=1 in the same cycle -> stall=0 and EX gets a bubble; reset during a stall -> sel 00, stall 0 next cycle.
REQ-036 FORWARD_CTRL_PERF_EN defined: three load-use pairs -> stall_count=3; count clears on reset.
